chnarrow: RTL and testbench

Parametrised multi-channel narrowing stage: accepts a vector of `NCH` signed 32-bit channel values per beat and converts each to a signed `OUT_W`-bit value, either by two's-complement wrap or by saturation. Results are buffered in a `DEPTH`-entry FIFO behind a valid/ready handshake. Per-channel saturating overflow counters are maintained. It generalises the earlier single-value, combinational integer-to-byte assign into a registered, flow-controlled, multi-channel block.

---
 rtl/chnarrow_pkg.sv | 48 ++++
 rtl/chnarrow_if.sv | 34 +++
 rtl/chnarrow_fifo.sv | 101 ++++++++++
 rtl/chnarrow.sv | 88 ++++++++
 tb/tb_chnarrow.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/chnarrow_pkg.sv
// chnarrow_pkg: shared types and arithmetic helpers for the channel narrowing stage.
// The helpers take the output width as an argument so that one package serves
// every parameterisation of the top.
package chnarrow_pkg;

    // Per-beat conversion mode.
    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } mode_e;

    // Most negative value representable in a signed w-bit field.
    function automatic int out_min(input int w);
        return -(32'sd1 <<< (w - 32'sd1));
    endfunction

    // Most positive value representable in a signed w-bit field.
    function automatic int out_max(input int w);
        return (32'sd1 <<< (w - 32'sd1)) - 32'sd1;
    endfunction

    // True when v cannot be represented in a signed w-bit field.
    function automatic logic is_ovf(input int v, input int w);
        return (v < out_min(w)) || (v > out_max(w));
    endfunction

    // Narrow v to a signed w-bit value, returned sign-extended to 32 bits.
    // Saturation clamps to the representable range; wrap keeps the low w bits
    // and reinterprets them as signed (shift up, then arithmetic shift down).
    function automatic int narrow(input int v, input bit sat, input int w);
        int sh;
        int r;
        sh = 32'sd32 - w;
        if (sat) begin
            if (v > out_max(w)) begin
                r = out_max(w);
            end else if (v < out_min(w)) begin
                r = out_min(w);
            end else begin
                r = v;
            end
        end else begin
            r = (v <<< sh) >>> sh;
        end
        return r;
    endfunction

endpackage

// File: rtl/chnarrow_if.sv
// chnarrow_if: input beat and output entry handshakes of the narrowing stage.
// The master side is the producer/consumer environment, the slave side the block.
interface chnarrow_if #(
    parameter int NCH   = 4,
    parameter int OUT_W = 8
);
    logic                      in_vld;
    logic                      in_rdy;
    int                        in_dat [0:NCH-1];
    logic                      sat;
    logic                      out_vld;
    logic                      out_rdy;
    logic [0:NCH-1][OUT_W-1:0] out_dat;

    modport master (
        output in_vld,
        output in_dat,
        output sat,
        output out_rdy,
        input  in_rdy,
        input  out_vld,
        input  out_dat
    );

    modport slave (
        input  in_vld,
        input  in_dat,
        input  sat,
        input  out_rdy,
        output in_rdy,
        output out_vld,
        output out_dat
    );
endinterface

// File: rtl/chnarrow_fifo.sv
// chnarrow_fifo: DEPTH-entry FIFO of W-bit words with a registered head.
// Pointers wrap at DEPTH, so any depth >= 2 works. The head register always
// holds the entry the read pointer will address after the current edge, with
// a bypass of the write data when that entry is being written in the same cycle.
module chnarrow_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 32,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          rvld,
    output logic          full,
    output logic [LW-1:0] level
);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] ONE_LVL  = LW'(1);

    logic [W-1:0]  mem_r [0:DEPTH-1];
    logic [PW-1:0] wptr_r;
    logic [PW-1:0] rptr_r;
    logic [LW-1:0] level_r;
    logic [W-1:0]  head_r;

    logic          do_push_s;
    logic          do_pop_s;
    logic          full_s;
    logic          rvld_s;
    logic [PW-1:0] wptr_nxt_s;
    logic [PW-1:0] rptr_nxt_s;
    logic [LW-1:0] level_nxt_s;
    logic [W-1:0]  head_nxt_s;

    // Pointer increment with wrap at DEPTH-1 rather than at a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == LAST) begin
            r = {PW{1'b0}};
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    assign full_s = (level_r == FULL_LVL);
    assign rvld_s = (level_r != {LW{1'b0}});

    // Next-state of pointers, occupancy and head; a full FIFO never accepts a
    // write, even when an entry leaves in the same cycle.
    always_comb begin
        do_push_s  = push && !full_s;
        do_pop_s   = pop && rvld_s;
        wptr_nxt_s = do_push_s ? ptr_inc(wptr_r) : wptr_r;
        rptr_nxt_s = do_pop_s  ? ptr_inc(rptr_r) : rptr_r;

        if (do_push_s && (wptr_r == rptr_nxt_s)) begin
            head_nxt_s = wdata;
        end else begin
            head_nxt_s = mem_r[rptr_nxt_s];
        end

        case ({do_push_s, do_pop_s})
            2'b10:   level_nxt_s = level_r + ONE_LVL;
            2'b01:   level_nxt_s = level_r - ONE_LVL;
            default: level_nxt_s = level_r;
        endcase
    end

    // Storage, pointers, occupancy and head register; reset discards all entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            level_r <= {LW{1'b0}};
            head_r  <= {W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wptr_r] <= wdata;
            end
            wptr_r  <= wptr_nxt_s;
            rptr_r  <= rptr_nxt_s;
            level_r <= level_nxt_s;
            head_r  <= head_nxt_s;
        end
    end

    assign rdata = head_r;
    assign rvld  = rvld_s;
    assign full  = full_s;
    assign level = level_r;

endmodule

// File: rtl/chnarrow.sv
// chnarrow: multi-channel narrowing stage. Each accepted beat of NCH signed
// 32-bit values is narrowed to OUT_W bits (wrap or saturate, chosen per beat),
// queued in a DEPTH-entry FIFO, and counted into saturating per-channel
// overflow counters at the accept edge.
module chnarrow
    import chnarrow_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int OUT_W = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    chnarrow_if.slave                     bus,
    input  logic                          clr,
    output logic [0:NCH-1][CNT_W-1:0]     ovf_cnt,
    output logic [$clog2(DEPTH+1)-1:0]    level
);
    localparam int               W       = NCH * OUT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mode_e                     mode_s;
    logic [0:NCH-1][OUT_W-1:0] conv_s;
    logic [0:NCH-1]            ovf_s;
    logic                      push_s;
    logic                      pop_s;
    logic                      full_s;
    logic                      vld_s;
    logic [W-1:0]              head_s;
    logic [0:NCH-1][CNT_W-1:0] cnt_r;

    assign mode_s = bus.sat ? SAT : WRAP;

    // Narrow every channel of the offered beat and flag out-of-range values.
    always_comb begin
        conv_s = {W{1'b0}};
        ovf_s  = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            conv_s[i] = OUT_W'(narrow(bus.in_dat[i], mode_s == SAT, OUT_W));
            ovf_s[i]  = is_ovf(bus.in_dat[i], OUT_W);
        end
    end

    // Ready depends only on the registered occupancy, never on out_rdy.
    assign push_s     = bus.in_vld && !full_s;
    assign pop_s      = bus.out_rdy && vld_s;
    assign bus.in_rdy = !full_s;

    chnarrow_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .wdata (conv_s),
        .pop   (pop_s),
        .rdata (head_s),
        .rvld  (vld_s),
        .full  (full_s),
        .level (level)
    );

    assign bus.out_vld = vld_s;
    assign bus.out_dat = head_s;

    // Per-channel overflow counters: clear wins, increments stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {(NCH * CNT_W){1'b0}};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr) begin
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else if (push_s && ovf_s[i] && (cnt_r[i] != CNT_MAX)) begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    assign ovf_cnt = cnt_r;

endmodule

// File: tb/tb_chnarrow.sv
// tb_chnarrow: directed self-checking bench. Two instances: DEPTH=4 for the
// basic, full and counter scenarios, DEPTH=3 for the odd-depth streaming run.
module tb_chnarrow;
    logic clk;
    logic rst_n;
    logic clr4;
    logic clr3;
    logic [0:3][7:0] ovf4;
    logic [0:3][7:0] ovf3;
    logic [2:0] lvl4;
    logic [1:0] lvl3;

    int n_chk;
    int n_fail;

    chnarrow_if #(.NCH(4), .OUT_W(8)) b4 ();
    chnarrow_if #(.NCH(4), .OUT_W(8)) b3 ();

    chnarrow #(.NCH(4), .OUT_W(8), .DEPTH(4), .CNT_W(8)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(b4), .clr(clr4), .ovf_cnt(ovf4), .level(lvl4)
    );
    chnarrow #(.NCH(4), .OUT_W(8), .DEPTH(3), .CNT_W(8)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(b3), .clr(clr3), .ovf_cnt(ovf3), .level(lvl3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input int a, input int b, input int c, input int d,
                          input logic s, input logic v);
        b4.in_dat[0] = a;
        b4.in_dat[1] = b;
        b4.in_dat[2] = c;
        b4.in_dat[3] = d;
        b4.sat       = s;
        b4.in_vld    = v;
    endtask

    // Reference narrowing to 8 bits using an 8-bit slice for wrap.
    function automatic logic [7:0] ref8(input int v, input logic s);
        logic [7:0] r;
        if (s && (v > 127)) begin
            r = 8'h7f;
        end else if (s && (v < -128)) begin
            r = 8'h80;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    logic [31:0] q [$];
    logic [15:0] rpat;
    int sent;
    int got;
    int occ;
    int va, vb, vc, vd;
    logic s3;
    logic acc;
    logic pop;

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        clr4 = 1'b0;
        clr3 = 1'b0;
        drive4(0, 0, 0, 0, 1'b0, 1'b0);
        b4.out_rdy = 1'b0;
        b3.in_vld = 1'b0;
        b3.sat = 1'b0;
        b3.out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) b3.in_dat[i] = 0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_vld", b4.out_vld, 1'b0);
        chk("rst_level", lvl4, 3'd0);
        chk("rst_in_rdy", b4.in_rdy, 1'b1);
        chk("rst_out_dat", b4.out_dat, 32'h0);
        chk("rst_ovf", ovf4, 32'h0);
        chk("rst_level3", lvl3, 2'd0);
        #2 rst_n = 1'b1;
        step();

        // Single in-range beat, saturate mode, visible the next cycle
        drive4(100, -100, 127, -128, 1'b1, 1'b1);
        step();
        drive4(300, -300, 128, -129, 1'b1, 1'b1);
        chk("a_out_vld", b4.out_vld, 1'b1);
        chk("a_out_dat", b4.out_dat, 32'h649c7f80);
        chk("a_ovf", ovf4, 32'h0);
        chk("a_level", lvl4, 3'd1);
        step();
        chk("b_ovf", ovf4, 32'h01010101);
        chk("b_head_hold", b4.out_dat, 32'h649c7f80);
        drive4(300, -300, 128, -129, 1'b0, 1'b1);
        step();
        drive4(0, 0, 0, 0, 1'b0, 1'b0);
        chk("c_ovf", ovf4, 32'h02020202);
        chk("c_level", lvl4, 3'd3);
        b4.out_rdy = 1'b1;
        step();
        chk("b_sat_dat", b4.out_dat, 32'h7f807f80);
        chk("b_level", lvl4, 3'd2);
        step();
        chk("c_wrap_dat", b4.out_dat, 32'h2cd4807f);
        step();
        chk("drain_vld", b4.out_vld, 1'b0);
        chk("drain_level", lvl4, 3'd0);
        b4.out_rdy = 1'b0;

        // Fill to DEPTH=4; the fifth beat must be refused
        for (int k = 0; k < 5; k++) begin
            drive4(k, 16 + k, 32 + k, 48 + k, 1'b1, 1'b1);
            chk("fill_in_rdy", b4.in_rdy, (k < 4) ? 1'b1 : 1'b0);
            step();
        end
        chk("full_level", lvl4, 3'd4);
        chk("full_in_rdy", b4.in_rdy, 1'b0);
        chk("full_head", b4.out_dat, 32'h00102030);
        // Pop while full with a beat offered: no write-through
        b4.out_rdy = 1'b1;
        chk("full_pop_in_rdy", b4.in_rdy, 1'b0);
        step();
        drive4(0, 0, 0, 0, 1'b0, 1'b0);
        chk("no_wt_level", lvl4, 3'd3);
        for (int k = 1; k < 4; k++) begin
            chk("drain_order", b4.out_dat, 32'h00102030 + k * 32'h01010101);
            step();
        end
        chk("drain4_level", lvl4, 3'd0);
        chk("drain4_vld", b4.out_vld, 1'b0);
        b4.out_rdy = 1'b0;

        // DEPTH=3 stream with an irregular consumer
        rpat = 16'b0110_1001_1101_0011;
        sent = 0;
        got = 0;
        occ = 0;
        for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
            va = sent * 90 - 400;
            vb = 150 - sent * 40;
            vc = sent * 13;
            vd = -sent * 29;
            s3 = ((sent % 2) == 1);
            b3.in_dat[0] = va;
            b3.in_dat[1] = vb;
            b3.in_dat[2] = vc;
            b3.in_dat[3] = vd;
            b3.sat = s3;
            b3.in_vld = (sent < 10);
            b3.out_rdy = rpat[cyc % 16];
            chk("s3_level", lvl3, occ);
            chk("s3_in_rdy", b3.in_rdy, (occ != 3));
            chk("s3_out_vld", b3.out_vld, (occ != 0));
            acc = b3.in_vld && b3.in_rdy;
            pop = b3.out_vld && b3.out_rdy;
            if (pop) begin
                chk("s3_data", b3.out_dat, q[0]);
                q.pop_front();
                got++;
            end
            if (acc) begin
                q.push_back({ref8(va, s3), ref8(vb, s3), ref8(vc, s3), ref8(vd, s3)});
                sent++;
            end
            occ = occ + (acc ? 1 : 0) - (pop ? 1 : 0);
            step();
        end
        b3.in_vld = 1'b0;
        b3.out_rdy = 1'b0;
        chk("s3_all_popped", got, 10);

        // Counter saturation on channel 0, then clear racing an overflow
        b4.out_rdy = 1'b1;
        drive4(1000, 0, 0, 0, 1'b1, 1'b1);
        repeat (300) step();
        chk("sat_cnt", ovf4, 32'hff020202);
        chk("sat_dat", b4.out_dat, 32'h7f000000);
        clr4 = 1'b1;
        step();
        clr4 = 1'b0;
        chk("clr_wins", ovf4, 32'h0);
        step();
        chk("post_clr_inc", ovf4, 32'h01000000);
        drive4(0, 0, 0, 0, 1'b0, 1'b0);
        step();
        chk("sat_drain_level", lvl4, 3'd0);
        b4.out_rdy = 1'b0;

        // Asynchronous reset with three entries held
        drive4(1, 2, 3, 4, 1'b0, 1'b1);
        repeat (3) step();
        drive4(0, 0, 0, 0, 1'b0, 1'b0);
        chk("pre_rst_level", lvl4, 3'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_vld", b4.out_vld, 1'b0);
        chk("arst_level", lvl4, 3'd0);
        chk("arst_in_rdy", b4.in_rdy, 1'b1);
        chk("arst_out_dat", b4.out_dat, 32'h0);
        #2 rst_n = 1'b1;
        step();
        drive4(-5, 5, 200, -200, 1'b1, 1'b1);
        step();
        drive4(0, 0, 0, 0, 1'b0, 1'b0);
        chk("post_rst_vld", b4.out_vld, 1'b1);
        chk("post_rst_dat", b4.out_dat, 32'hfb057f80);
        chk("post_rst_level", lvl4, 3'd1);
        chk("post_rst_ovf", ovf4, 32'h00000101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
